// File: rtl/sl_receiver.sv
// SL two-wire serial link receiver.
// Synchronizes the zeroes/ones lines, classifies low pulses into 0/1/STOP symbols,
// assembles one frame and reports its data word and status.
module sl_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        serial_line_zeroes_a,
  input  logic        serial_line_ones_a,
  input  logic        wr_enable,
  input  logic [15:0] wr_config_w,
  output logic [15:0] r_config_w,
  output logic [31:0] data_w,
  output logic [15:0] status_w
);

  typedef enum logic {IDLE, LOW} state_t;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] sync_z, sync_o;
  logic                   z, o;
  logic                   commit;
  logic                   low_z, low_o;
  logic [5:0]             cfg_n;
  logic                   cfg_pce;
  logic [5:0]             cnt;
  logic [31:0]            shift_data;
  logic                   zero_par;
  logic [31:0]            data_mask;
  logic [6:0]             frame_len_exp;
  logic                   unused_cfg_bits;

  assign unused_cfg_bits = ^wr_config_w[15:7];
  assign z               = sync_z[SYNC_STAGES-1];
  assign o               = sync_o[SYNC_STAGES-1];
  assign r_config_w      = {9'b0, cfg_n, cfg_pce};
  assign frame_len_exp   = {1'b0, cfg_n} + 7'd1;

  // Input synchronizers, preset to the idle-high level on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_z <= '1;
      sync_o <= '1;
    end else begin
      sync_z <= {sync_z[SYNC_STAGES-2:0], serial_line_zeroes_a};
      sync_o <= {sync_o[SYNC_STAGES-2:0], serial_line_ones_a};
    end
  end

  // Symbol detection state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: a symbol commits when both lines are back high after a low pulse.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    case (state)
      IDLE:    if (!z || !o) next_state = LOW;
      LOW:     if (z && o) begin
                 next_state = IDLE;
                 commit     = 1'b1;
               end
      default: next_state = IDLE;
    endcase
    if (wr_enable) begin
      next_state = IDLE;
      commit     = 1'b0;
    end
  end

  // Keep only the first N data bits (all 32 when N >= 32).
  always_comb begin
    data_mask = 32'hFFFF_FFFF;
    if (!cfg_n[5]) data_mask = (32'd1 << cfg_n[4:0]) - 32'd1;
  end

  // Config register, low-pulse accumulators, frame assembly and result registers.
  // zero_par counts every 0-symbol including the parity symbol; the frame parity is
  // correct exactly when that total is even, so no separate parity bit is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_n      <= '0;
      cfg_pce    <= 1'b0;
      data_w     <= '0;
      status_w   <= '0;
      cnt        <= '0;
      shift_data <= '0;
      zero_par   <= 1'b0;
      low_z      <= 1'b0;
      low_o      <= 1'b0;
    end else if (wr_enable) begin
      cfg_pce    <= wr_config_w[0];
      cfg_n      <= wr_config_w[6:1];
      cnt        <= '0;
      shift_data <= '0;
      zero_par   <= 1'b0;
      low_z      <= 1'b0;
      low_o      <= 1'b0;
    end else begin
      if (state == IDLE) begin
        low_z <= 1'b0;
        low_o <= 1'b0;
      end else begin
        low_z <= low_z | ~z;
        low_o <= low_o | ~o;
      end
      if (commit) begin
        if (low_z && low_o) begin
          if (cnt != 6'd0) begin
            if ({1'b0, cnt} != frame_len_exp) begin
              status_w <= 16'h0009;
              data_w   <= '0;
            end else if (cfg_pce && zero_par) begin
              status_w <= 16'h0018;
              data_w   <= '0;
            end else begin
              status_w <= 16'h0008;
              data_w   <= shift_data & data_mask;
            end
            cnt        <= '0;
            shift_data <= '0;
            zero_par   <= 1'b0;
          end
        end else if (low_z || low_o) begin
          if (!cnt[5]) shift_data[cnt[4:0]] <= low_o;
          if (!low_o) zero_par <= ~zero_par;
          if (cnt != 6'd63) cnt <= cnt + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sl_receiver.sv
// Scoreboard testbench for sl_receiver: stimulus pushes expected results per frame,
// a monitor pops and compares once the result is due.
module tb_sl_receiver;

  localparam int SYNC_STAGES = 2;
  localparam int LOW_CLKS    = 6;
  localparam int GAP_CLKS    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        serial_line_zeroes_a;
  logic        serial_line_ones_a;
  logic        wr_enable;
  logic [15:0] wr_config_w;
  logic [15:0] r_config_w;
  logic [31:0] data_w;
  logic [15:0] status_w;

  typedef struct {
    logic [31:0] data;
    logic [15:0] status;
    logic [15:0] cfg;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cycle = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] cur_cfg = 16'h0000;

  sl_receiver #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .serial_line_zeroes_a (serial_line_zeroes_a),
    .serial_line_ones_a   (serial_line_ones_a),
    .wr_enable            (wr_enable),
    .wr_config_w          (wr_config_w),
    .r_config_w           (r_config_w),
    .data_w               (data_w),
    .status_w             (status_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the DUT result once each expected frame result is due.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && cycle >= exp_q[0].due) begin
        e = exp_q.pop_front();
        chk("data_w", data_w, e.data);
        chk("status_w", {16'h0, status_w}, {16'h0, e.status});
        chk("r_config_w", {16'h0, r_config_w}, {16'h0, e.cfg});
      end
    end
  end

  task automatic push_exp(input logic [31:0] d, input logic [15:0] s);
    exp_t e;
    e.data   = d;
    e.status = s;
    e.cfg    = cur_cfg;
    e.due    = cycle + SYNC_STAGES + 2;
    exp_q.push_back(e);
  endtask

  // kind: 0 = bit 0 (zeroes low), 1 = bit 1 (ones low), 2 = STOP (both low)
  task automatic sym(input int kind);
    @(negedge clk);
    serial_line_zeroes_a = !(kind == 0 || kind == 2);
    serial_line_ones_a   = !(kind == 1 || kind == 2);
    repeat (LOW_CLKS) @(negedge clk);
    serial_line_zeroes_a = 1'b1;
    serial_line_ones_a   = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_cfg(input logic [15:0] v, input logic [15:0] exp_rb);
    @(negedge clk);
    wr_enable   = 1'b1;
    wr_config_w = v;
    @(negedge clk);
    wr_enable   = 1'b0;
    wr_config_w = 16'h0;
    cur_cfg     = exp_rb;
    chk("r_config_w after write", {16'h0, r_config_w}, {16'h0, exp_rb});
  endtask

  // Sends n data bits LSB first, a parity symbol (optionally inverted), then STOP.
  task automatic frame(input logic [63:0] bits, input int n, input bit inv,
                       input logic [31:0] exp_d, input logic [15:0] exp_s);
    int zeros = 0;
    int p0;
    for (int i = 0; i < n; i++) begin
      sym(bits[i] ? 1 : 0);
      if (!bits[i]) zeros++;
      gap(GAP_CLKS);
    end
    p0 = (1 ^ (zeros % 2)) ^ int'(inv);
    sym(p0);
    gap(GAP_CLKS);
    sym(2);
    push_exp(exp_d, exp_s);
    gap(LOW_CLKS);
  endtask

  initial begin
    logic [19:0] good1 [5];
    logic [19:0] good2 [5];
    good1 = '{20'h12345, 20'h0ABCD, 20'hFFFFF, 20'h00000, 20'h5A5A5};
    good2 = '{20'h11111, 20'h22222, 20'h33333, 20'hFEDCB, 20'h7C3E1};

    rst_n = 1'b0;
    serial_line_zeroes_a = 1'b1;
    serial_line_ones_a   = 1'b1;
    wr_enable   = 1'b0;
    wr_config_w = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset data_w", data_w, 32'h0);
    chk("reset status_w", {16'h0, status_w}, 32'h0);
    chk("reset r_config_w", {16'h0, r_config_w}, 32'h0);
    rst_n = 1'b1;
    gap(2);

    // N=10, PCE=0; upper write bits ignored
    write_cfg(16'hFF94, 16'h0014);
    frame(64'h2A5, 10, 1'b0, 32'h0000_02A5, 16'h0008);
    // STOP with no preceding symbols changes nothing
    sym(2);
    push_exp(32'h0000_02A5, 16'h0008);
    gap(LOW_CLKS);

    // N=40, PCE=1: bits above 31 are discarded
    write_cfg(16'h0051, 16'h0051);
    frame(64'h00_DEAD_BEEF, 40, 1'b0, 32'hDEAD_BEEF, 16'h0008);

    // N=20, PCE=1: good frames, a long frame, good frames
    write_cfg(16'h0029, 16'h0029);
    for (int i = 0; i < 5; i++) frame({44'h0, good1[i]}, 20, 1'b0, {12'h0, good1[i]}, 16'h0008);
    frame(64'h3F_FFFF, 22, 1'b0, 32'h0, 16'h0009);
    for (int i = 0; i < 5; i++) frame({44'h0, good2[i]}, 20, 1'b0, {12'h0, good2[i]}, 16'h0008);

    // Short and long frames
    frame(64'h2_5555, 18, 1'b0, 32'h0, 16'h0009);
    frame(64'h2AA_AAAA, 26, 1'b0, 32'h0, 16'h0009);

    // N=16 with inverted parity, PCE on then off
    write_cfg(16'h0021, 16'h0021);
    frame(64'h1234, 16, 1'b1, 32'h0, 16'h0018);
    write_cfg(16'h0020, 16'h0020);
    frame(64'h1234, 16, 1'b1, 32'h0000_1234, 16'h0008);

    // Reset in the middle of a frame
    write_cfg(16'h0014, 16'h0014);
    for (int i = 0; i < 4; i++) begin
      sym(i % 2);
      gap(GAP_CLKS);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cur_cfg = 16'h0000;
    chk("midreset data_w", data_w, 32'h0);
    chk("midreset status_w", {16'h0, status_w}, 32'h0);
    chk("midreset r_config_w", {16'h0, r_config_w}, 32'h0);
    gap(2);
    write_cfg(16'h0014, 16'h0014);
    frame(64'h155, 10, 1'b0, 32'h0000_0155, 16'h0008);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d results pending, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
